// File: rtl/shift_pipe_unit_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings used by
// the top level and by every shift stage.
package shift_pipe_unit_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_pipe_unit_stage.sv
// One purely combinational barrel-shifter stage: shifts or rotates by SHIFT
// bit positions when enabled and reports the last bit pushed out.
module shift_pipe_stage
    import shift_pipe_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  mode_t            mode,
    input  logic             enable,
    input  logic             sign,
    input  logic             carry,
    output logic [WIDTH-1:0] shifted,
    output logic             shifted_carry
);

    // A disabled stage passes both data and the carry from earlier stages through.
    always_comb begin
        shifted       = data;
        shifted_carry = carry;
        if (enable) begin
            case (mode)
                MODE_SLL: begin
                    shifted       = data << SHIFT;
                    shifted_carry = data[WIDTH-SHIFT];
                end
                MODE_SRL: begin
                    shifted       = data >> SHIFT;
                    shifted_carry = data[SHIFT-1];
                end
                MODE_SRA: begin
                    shifted       = {{SHIFT{sign}}, data[WIDTH-1:SHIFT]};
                    shifted_carry = data[SHIFT-1];
                end
                MODE_ROR: begin
                    shifted       = {data[SHIFT-1:0], data[WIDTH-1:SHIFT]};
                    shifted_carry = data[SHIFT-1];
                end
                default: begin
                    shifted       = data;
                    shifted_carry = carry;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe_unit.sv
// Pipelined barrel shifter: one registered stage per amount bit, wrapped in a
// valid/ready handshake with a single global stall.
module shift_pipe_unit
    import shift_pipe_unit_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LOG2W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic             en;

    logic [WIDTH-1:0] src_data  [LOG2W];
    mode_t            src_mode  [LOG2W];
    logic             src_sign  [LOG2W];
    logic             src_carry [LOG2W];
    logic             src_valid [LOG2W];
    logic [LOG2W-1:0] src_amt   [LOG2W];

    logic [WIDTH-1:0] res_data  [LOG2W];
    logic             res_carry [LOG2W];
    logic             nxt_carry [LOG2W];

    logic [WIDTH-1:0] data_q    [LOG2W];
    logic             carry_q   [LOG2W];
    logic             valid_q   [LOG2W];
    mode_t            mode_q    [LOG2W-1];
    logic             sign_q    [LOG2W-1];
    logic [LOG2W-1:0] amt_q     [LOG2W-1];
    logic             zero_q;

    assign en       = !valid_q[LOG2W-1] || out_ready;
    assign in_ready = en;

    // Stage 0 is fed straight from the inputs; later stages read the register
    // of the stage in front of them. The sign is captured once, from the operand.
    always_comb begin
        src_data[0]  = in_data;
        src_mode[0]  = mode_t'(in_mode);
        src_sign[0]  = in_data[WIDTH-1];
        src_carry[0] = 1'b0;
        src_valid[0] = in_valid;
        src_amt[0]   = in_amt;
        for (int k = 1; k < LOG2W; k++) begin
            src_data[k]  = data_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_carry[k] = carry_q[k-1];
            src_valid[k] = valid_q[k-1];
            src_amt[k]   = amt_q[k-1];
        end
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .data          (src_data[k]),
            .mode          (src_mode[k]),
            .enable        (src_amt[k][k]),
            .sign          (src_sign[k]),
            .carry         (src_carry[k]),
            .shifted       (res_data[k]),
            .shifted_carry (res_carry[k])
        );
    end

    // Rotation has no real "shifted out" bit, so the final carry of a non-zero
    // rotate is defined as the MSB of the result.
    always_comb begin
        for (int k = 0; k < LOG2W; k++) begin
            nxt_carry[k] = res_carry[k];
        end
        if (src_mode[LOG2W-1] == MODE_ROR && src_amt[LOG2W-1] != '0) begin
            nxt_carry[LOG2W-1] = res_data[LOG2W-1][WIDTH-1];
        end
    end

    // Every stage, bubbles included, advances together whenever the output is
    // free or being taken; otherwise the whole pipe freezes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LOG2W; k++) begin
                data_q[k]  <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                mode_q[k] <= MODE_SLL;
                sign_q[k] <= 1'b0;
                amt_q[k]  <= '0;
            end
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < LOG2W; k++) begin
                data_q[k]  <= res_data[k];
                carry_q[k] <= nxt_carry[k];
                valid_q[k] <= src_valid[k];
            end
            for (int k = 0; k < LOG2W - 1; k++) begin
                mode_q[k] <= src_mode[k];
                sign_q[k] <= src_sign[k];
                amt_q[k]  <= src_amt[k];
            end
            zero_q <= (res_data[LOG2W-1] == '0);
        end
    end

    assign out_valid = valid_q[LOG2W-1];
    assign out_data  = data_q[LOG2W-1];
    assign out_carry = carry_q[LOG2W-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Self-checking bench for shift_pipe_unit at WIDTH=8: directed vectors,
// back-pressure, mid-flight reset and a randomised scoreboard run.
module tb_shift_pipe_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic       out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_pipe_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    // Reference model from the mode definitions; returns {carry, data}.
    function automatic logic [8:0] model(input logic [7:0] d, input logic [2:0] a,
                                         input logic [1:0] m);
        logic [7:0] r;
        logic       c;
        int         n;
        n = int'(a);
        c = 1'b0;
        case (m)
            2'b00: begin
                r = d << n;
                if (n != 0) c = d[8-n];
            end
            2'b01: begin
                r = d >> n;
                if (n != 0) c = d[n-1];
            end
            2'b10: begin
                r = 8'($signed(d) >>> n);
                if (n != 0) c = d[n-1];
            end
            default: begin
                r = (d >> n) | (d << (8 - n));
                if (n != 0) c = r[7];
            end
        endcase
        return {c, r};
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got data=%h carry=%b zero=%b expected 00/0/0",
                     out_data, out_carry, out_zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes();
        logic [7:0] v_data [8] = '{8'h96, 8'h96, 8'h80, 8'h80, 8'h96, 8'h96, 8'h01, 8'hF0};
        logic [2:0] v_amt  [8] = '{3'd3, 3'd2, 3'd7, 3'd7, 3'd4, 3'd0, 3'd0, 3'd4};
        logic [1:0] v_mode [8] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
        logic [7:0] e_data [8] = '{8'hB0, 8'hE5, 8'h01, 8'hFF, 8'h69, 8'h96, 8'h01, 8'h00};
        logic       e_carry[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int cycles;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = v_data[i];
            in_amt   = v_amt[i];
            in_mode  = v_mode[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            cycles   = 1;
            while (out_valid !== 1'b1 && cycles < 10) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            checks++;
            if (cycles != 3) begin
                errors++;
                $display("[TB] FAIL latency_%0d: got %0d cycles expected 3", i, cycles);
            end
            checks++;
            if (out_data !== e_data[i]) begin
                errors++;
                $display("[TB] FAIL data_%0d: got %h expected %h", i, out_data, e_data[i]);
            end
            checks++;
            if (out_carry !== e_carry[i]) begin
                errors++;
                $display("[TB] FAIL carry_%0d: got %b expected %b", i, out_carry, e_carry[i]);
            end
            checks++;
            if (out_zero !== (e_data[i] == 8'h00)) begin
                errors++;
                $display("[TB] FAIL zero_%0d: got %b expected %b", i, out_zero, e_data[i] == 8'h00);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_delivery_%0d: got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v_data [5] = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h0F};
        logic [2:0] v_amt  [5] = '{3'd1, 3'd1, 3'd3, 3'd2, 3'd5};
        logic [1:0] v_mode [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [7:0] e_data [5] = '{8'h2C, 8'h4B, 8'hF2, 8'hA5, 8'hE0};
        logic       e_carry[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int  sent = 0;
        int  recv = 0;
        int  stall_left = 4;
        int  stalled = 0;
        int  cyc = 0;
        logic acc;
        while (recv < 5 && cyc < 40) begin
            if (out_valid === 1'b1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < 5);
            if (sent < 5) begin
                in_data = v_data[sent];
                in_amt  = v_amt[sent];
                in_mode = v_mode[sent];
            end
            #1;
            if (out_ready == 1'b0) begin
                stalled++;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL stall_in_ready_c%0d: got %b expected 0", cyc, in_ready);
                end
                checks++;
                if (out_data !== e_data[recv] || out_carry !== e_carry[recv]) begin
                    errors++;
                    $display("[TB] FAIL stall_hold_c%0d: got %h/%b expected %h/%b",
                             cyc, out_data, out_carry, e_data[recv], e_carry[recv]);
                end
            end else begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL run_in_ready_c%0d: got %b expected 1", cyc, in_ready);
                end
                if (out_valid === 1'b1) begin
                    checks++;
                    if (out_data !== e_data[recv] || out_carry !== e_carry[recv] ||
                        out_zero !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL b2b_result_%0d: got %h/%b/%b expected %h/%b/0",
                                 recv, out_data, out_carry, out_zero, e_data[recv], e_carry[recv]);
                    end
                    recv++;
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 5 || stalled != 4) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got recv=%0d stalled=%0d expected 5 and 4", recv, stalled);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_extra_%0d: got out_valid=%b expected 0", i, out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int cycles;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h96;
        in_amt    = 3'd1;
        in_mode   = 2'b00;
        @(posedge clk);
        #1;
        in_mode = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h2C || out_carry !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_result: got v=%b %h/%b expected 1 2C/1",
                     out_valid, out_data, out_carry);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_outputs: got %h/%b/%b expected 00/0/0",
                     out_data, out_carry, out_zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL stale_after_reset: got %0d outputs expected 0", seen);
        end
        in_valid = 1'b1;
        in_data  = 8'h96;
        in_amt   = 3'd4;
        in_mode  = 2'b11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles   = 1;
        while (out_valid !== 1'b1 && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checks++;
        if (cycles != 3 || out_data !== 8'h69 || out_carry !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_op: got %0d cycles %h/%b expected 3 cycles 69/0",
                     cycles, out_data, out_carry);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [8:0] sb[$];
        logic [8:0] head;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic acc;
        logic [8:0] exp_acc;
        while (recv < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 8);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_mode   = 2'($urandom);
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_unexpected_c%0d: got %h with none outstanding", cyc, out_data);
                end else begin
                    head = sb[0];
                    if (out_data !== head[7:0] || out_carry !== head[8] ||
                        out_zero !== (head[7:0] == 8'h00)) begin
                        errors++;
                        $display("[TB] FAIL rand_result_%0d: got %h/%b/%b expected %h/%b/%b",
                                 recv, out_data, out_carry, out_zero, head[7:0], head[8],
                                 head[7:0] == 8'h00);
                    end
                    if (out_ready) begin
                        void'(sb.pop_front());
                        recv++;
                    end
                end
            end
            acc     = in_valid && in_ready;
            exp_acc = model(in_data, in_amt, in_mode);
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(exp_acc);
                sent++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (recv != 10000) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d results expected 10000", recv);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
